tri_bus_drive_ctrl: RTL and testbench

//  Upstream controller for the 8-bit tri-state bus driver. Buffers words from a producer
//  in a small FIFO and arbitrates for the shared bus. Generates data_in/enable for the
//  tri-state buffer, one word per target acknowledge.

---
 rtl/tri_bus_drive_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_tri_bus_drive_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tri_bus_drive_ctrl.sv
// ---------------------------------------------------------------------------
// tri_bus_drive_ctrl
//   Upstream controller for an 8-bit tri-state bus driver. Producer words are
//   buffered in a small FIFO. The block requests the shared bus and then drives
//   one word per target acknowledge through the tri-state buffer's data_in and
//   enable. After it releases the bus it stays idle for a turnaround gap, so two
//   drivers never overlap on the bus.
//
//   Optional feature macro: BUS_BURST_LIMIT_EN
//     When it is defined, one grant is limited to MAX_BURST acknowledged words.
//     After the last of them the block releases the bus and requests it again.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_data     producer word
//   in_valid    producer word valid
//   in_ready    FIFO can accept a word (fifo_count < FIFO_DEPTH)
//   bus_req     request to the bus arbiter
//   bus_grant   arbiter grant (level)
//   bus_ack     target accepted the word currently driven
//   drv_data    tri-state buffer data_in (0 whenever drv_en=0)
//   drv_en      tri-state buffer enable
//   fifo_count  number of words held
//   busy        state != IDLE or FIFO not empty
// ---------------------------------------------------------------------------
module tri_bus_drive_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        bus_req,
    input  logic                        bus_grant,
    input  logic                        bus_ack,
    output logic [DATA_WIDTH-1:0]       drv_data,
    output logic                        drv_en,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRIVE = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [TURN_W-1:0]       turn_cnt;

    logic                    push;
    logic                    pop;
    logic                    last_word;
    logic                    turn_done;
    logic                    burst_done;

    // A lost grant takes priority over an ack in the same cycle: no pop.
    assign push      = in_valid && in_ready;
    assign pop       = (state == ST_DRIVE) && bus_grant && bus_ack;
    assign last_word = (count == CNT_W'(1)) && !push;
    assign turn_done = (turn_cnt == TURN_W'(TURNAROUND - 1));

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef BUS_BURST_LIMIT_EN
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    logic [BURST_W-1:0] burst_cnt;

    // Acks within the current DRIVE period; held at zero outside DRIVE so
    // every new DRIVE period starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (state != ST_DRIVE) begin
            burst_cnt <= '0;
        end else if (pop) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
        end
    end

    assign burst_done = (burst_cnt == BURST_W'(MAX_BURST - 1));
`else
    logic unused_max_burst;

    assign unused_max_burst = |MAX_BURST;
    assign burst_done       = 1'b0;
`endif

    // Turnaround gap counter; runs only while in TURN.
    always_ff @(posedge clk) begin
        if (rst) begin
            turn_cnt <= '0;
        end else if (state != ST_TURN) begin
            turn_cnt <= '0;
        end else if (!turn_done) begin
            turn_cnt <= turn_cnt + TURN_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_grant) begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!bus_grant) begin
                    state_nxt = ST_TURN;
                end else if (bus_ack && (last_word || burst_done)) begin
                    state_nxt = ST_TURN;
                end
            end
            ST_TURN: begin
                if (turn_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus controls are decoded from the registered state only.
    assign bus_req    = (state == ST_REQ) || (state == ST_DRIVE);
    assign drv_en     = (state == ST_DRIVE);
    assign drv_data   = drv_en ? mem[rd_ptr] : '0;
    assign fifo_count = count;
    assign in_ready   = (count < CNT_W'(FIFO_DEPTH));
    assign busy       = (state != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_tri_bus_drive_ctrl.sv
module tb_tri_bus_drive_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       bus_req;
    logic       bus_grant;
    logic       bus_ack;
    logic [7:0] drv_data;
    logic       drv_en;
    logic [2:0] fifo_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    tri_bus_drive_ctrl #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .TURNAROUND(1),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bus_req   (bus_req),
        .bus_grant (bus_grant),
        .bus_ack   (bus_ack),
        .drv_data  (drv_data),
        .drv_en    (drv_en),
        .fifo_count(fifo_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       g;
        logic       a;
        logic       req;
        logic       en;
        logic [7:0] data;
        logic [2:0] cnt;
        logic       rdy;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic g, input logic a,
                       input logic req, input logic en, input logic [7:0] data,
                       input logic [2:0] cnt, input logic rdy, input logic bsy);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.g = g; t.a = a;
        t.req = req; t.en = en; t.data = data; t.cnt = cnt; t.rdy = rdy; t.busy = bsy;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Words seen while driven and acked, plus DRIVE period lengths.
    logic [7:0] seen[$];
    int         period_len[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; bus_grant = 1'b0; bus_ack = 1'b0;

        //   rst v  d      g  a   req en data  cnt rdy busy
        add(1, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 1, 0);  // reset state
        // single word, grant held
        add(0, 1, 8'hA5, 1, 0,   0, 0, 8'h00, 1, 1, 1);
        add(0, 0, 8'h00, 1, 0,   1, 0, 8'h00, 1, 1, 1);  // REQ
        add(0, 0, 8'h00, 1, 0,   1, 1, 8'hA5, 1, 1, 1);  // DRIVE
        add(0, 0, 8'h00, 1, 1,   0, 0, 8'h00, 0, 1, 1);  // TURN
        add(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 0);  // IDLE
        add(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 0);
        // fill without grant, then full
        add(0, 1, 8'h01, 0, 0,   0, 0, 8'h00, 1, 1, 1);
        add(0, 1, 8'h02, 0, 0,   1, 0, 8'h00, 2, 1, 1);
        add(0, 1, 8'h03, 0, 0,   1, 0, 8'h00, 3, 1, 1);
        add(0, 1, 8'h04, 0, 0,   1, 0, 8'h00, 4, 0, 1);
        add(0, 1, 8'hEE, 0, 0,   1, 0, 8'h00, 4, 0, 1);  // refused while full
        add(0, 0, 8'h00, 1, 0,   1, 1, 8'h01, 4, 0, 1);
        add(0, 0, 8'h00, 1, 1,   1, 1, 8'h02, 3, 1, 1);
        add(0, 1, 8'h05, 1, 1,   1, 1, 8'h03, 3, 1, 1);
        add(0, 1, 8'h06, 1, 0,   1, 1, 8'h03, 4, 0, 1);
        add(0, 0, 8'h00, 1, 1,   1, 1, 8'h04, 3, 1, 1);
        add(0, 1, 8'h07, 1, 1,   1, 1, 8'h05, 3, 1, 1);
        add(0, 1, 8'h08, 1, 1,   1, 1, 8'h06, 3, 1, 1);
        add(0, 1, 8'h09, 1, 1,   1, 1, 8'h07, 3, 1, 1);
        add(0, 1, 8'h0A, 1, 1,   1, 1, 8'h08, 3, 1, 1);
        add(0, 0, 8'h00, 1, 1,   1, 1, 8'h09, 2, 1, 1);
        add(0, 0, 8'h00, 1, 1,   1, 1, 8'h0A, 1, 1, 1);
        add(0, 0, 8'h00, 1, 1,   0, 0, 8'h00, 0, 1, 1);
        add(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 0);
        // grant lost with ack in the same cycle
        add(0, 1, 8'h11, 1, 0,   0, 0, 8'h00, 1, 1, 1);
        add(0, 1, 8'h22, 1, 0,   1, 0, 8'h00, 2, 1, 1);
        add(0, 0, 8'h00, 1, 0,   1, 1, 8'h11, 2, 1, 1);
        add(0, 0, 8'h00, 0, 1,   0, 0, 8'h00, 2, 1, 1);  // no pop
        add(0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 2, 1, 1);
        add(0, 0, 8'h00, 0, 0,   1, 0, 8'h00, 2, 1, 1);
        add(0, 0, 8'h00, 0, 0,   1, 0, 8'h00, 2, 1, 1);
        add(0, 0, 8'h00, 1, 0,   1, 1, 8'h11, 2, 1, 1);  // same word again
        add(0, 0, 8'h00, 1, 1,   1, 1, 8'h22, 1, 1, 1);
        add(0, 0, 8'h00, 1, 1,   0, 0, 8'h00, 0, 1, 1);
        add(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 0);
        // reset in DRIVE with 3 words buffered
        add(0, 1, 8'h31, 1, 0,   0, 0, 8'h00, 1, 1, 1);
        add(0, 1, 8'h32, 1, 0,   1, 0, 8'h00, 2, 1, 1);
        add(0, 1, 8'h33, 1, 0,   1, 1, 8'h31, 3, 1, 1);
        add(1, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 0);
        add(0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 1, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; in_valid = vecs[i].v; in_data = vecs[i].d;
            bus_grant = vecs[i].g; bus_ack = vecs[i].a;
            @(posedge clk);
            #1;
            check("bus_req",    i, 32'(bus_req),    32'(vecs[i].req));
            check("drv_en",     i, 32'(drv_en),     32'(vecs[i].en));
            check("drv_data",   i, 32'(drv_data),   32'(vecs[i].data));
            check("fifo_count", i, 32'(fifo_count), 32'(vecs[i].cnt));
            check("in_ready",   i, 32'(in_ready),   32'(vecs[i].rdy));
            check("busy",       i, 32'(busy),       32'(vecs[i].busy));
        end

        // Burst: 6 words 0x41..0x46 streamed in, grant held, ack every cycle.
        begin
            int  pushed = 0;
            logic prev_en = 1'b0;
            rst = 1'b0; bus_grant = 1'b1; bus_ack = 1'b1;
            for (int cyc = 0; cyc < 40 && seen.size() < 6; cyc++) begin
                in_valid = (pushed < 6);
                in_data  = 8'(8'h41 + pushed);
                #1;
                if (drv_en && !prev_en) period_len.push_back(0);
                if (drv_en) begin
                    seen.push_back(drv_data);
                    period_len[period_len.size() - 1]++;
                end
                prev_en = drv_en;
                if (in_valid && in_ready) pushed++;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0; bus_ack = 1'b0;
            check("burst_words", 0, 32'(seen.size()), 32'd6);
            for (int k = 0; k < 6; k++) begin
                if (k < seen.size()) check("burst_order", k, 32'(seen[k]), 32'(8'h41 + k));
            end
`ifdef BUS_BURST_LIMIT_EN
            check("burst_periods", 0, 32'(period_len.size()), 32'd2);
            if (period_len.size() == 2) begin
                check("burst_len0", 0, 32'(period_len[0]), 32'd4);
                check("burst_len1", 1, 32'(period_len[1]), 32'd2);
            end
`else
            check("burst_periods", 0, 32'(period_len.size()), 32'd1);
            if (period_len.size() == 1) check("burst_len0", 0, 32'(period_len[0]), 32'd6);
`endif
            @(posedge clk);
            #1;
            check("burst_end_en",    0, 32'(drv_en),     32'd0);
            check("burst_end_count", 0, 32'(fifo_count), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
